// File: rtl/sync_fifo_param.sv
// Single-clock first-word-fall-through FIFO with arbitrary depth, occupancy count and thresholds.
// Optional macro SYNC_FIFO_PARAM_STICKY_ERR_EN makes overflow/underflow sticky until reset or flush.
module sync_fifo_param #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned DEPTH    = 5,
  parameter int unsigned AF_LEVEL = 4,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             data,
  output logic [WIDTH-1:0]             out,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          overflow_q,  overflow_d;
  logic          underflow_q, underflow_d;

  logic push_ok, pop_ok;
  logic ovf_ev, unf_ev;

  // Status decode straight from registered occupancy
  assign empty        = (count_q == '0);
  assign full         = (count_q == FULL_CNT);
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign count        = count_q;
  assign out          = empty ? '0 : mem_q[rd_ptr_q];
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A pop on a full FIFO frees the slot the same-cycle push lands in
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign ovf_ev  = push & ~push_ok;
  assign unf_ev  = pop & ~pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == LAST_IDX) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
`ifdef SYNC_FIFO_PARAM_STICKY_ERR_EN
    if (!flush) begin
      overflow_d  = overflow_q  | ovf_ev;
      underflow_d = underflow_q | unf_ev;
    end
`else
    if (!flush) begin
      overflow_d  = ovf_ev;
      underflow_d = unf_ev;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset; reset and flush only block the write
  always_ff @(posedge clk) begin
    if (rstn && !flush && push_ok) begin
      mem_q[wr_ptr_q] <= data;
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed plus randomised bench for sync_fifo_param with a queue scoreboard.
// Expects sticky error flags when SYNC_FIFO_PARAM_STICKY_ERR_EN is defined.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rstn, push, pop, flush;
  logic [3:0] data, out;
  logic       full, empty, almost_full, almost_empty;
  logic [2:0] count;
  logic       overflow, underflow;

  int passed = 0;
  int total  = 0;

  logic [3:0] model [$];
  logic       ovf_m = 1'b0;
  logic       unf_m = 1'b0;

  sync_fifo_param #(.WIDTH(4), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) dut (
    .clk(clk), .rstn(rstn), .push(push), .pop(pop), .flush(flush), .data(data),
    .out(out), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = model.size();
    check("count", count, sz);
    check("empty", empty, sz == 0);
    check("full", full, sz == 5);
    check("almost_full", almost_full, sz >= 4);
    check("almost_empty", almost_empty, sz <= 1);
    check("out", out, (sz > 0) ? model[0] : 4'h0);
    check("overflow", overflow, ovf_m);
    check("underflow", underflow, unf_m);
  endtask

  task automatic step(input logic r, input logic pu, input logic po,
                      input logic fl, input logic [3:0] d);
    int  sz;
    bit  pop_ok, push_ok, ovf, unf;
    rstn = r; push = pu; pop = po; flush = fl; data = d;
    sz      = model.size();
    pop_ok  = po && (sz > 0);
    push_ok = pu && ((sz < 5) || pop_ok);
    ovf     = pu && !push_ok;
    unf     = po && !pop_ok;
    if (r && !fl && pop_ok) check("pop_data", out, model[0]);
    @(posedge clk);
    #1;
    if (!r || fl) begin
      model.delete();
      ovf_m = 1'b0;
      unf_m = 1'b0;
    end else begin
      if (pop_ok)  void'(model.pop_front());
      if (push_ok) model.push_back(d);
`ifdef SYNC_FIFO_PARAM_STICKY_ERR_EN
      ovf_m = ovf_m | ovf;
      unf_m = unf_m | unf;
`else
      ovf_m = ovf;
      unf_m = unf;
`endif
    end
    check_all();
  endtask

  initial begin
    rstn = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0; data = '0;
    #1;
    // Reset
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'h9);
    // Fill to full
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'(i));
      check("head_stays_1", out, 4'h1);
    end
    // Overflow, then push+pop while full
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h6);
    check("ovf_set", overflow, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'h7);
    check("out_after_pp", out, 4'h2);
    check("count_after_pp", count, 3'd5);
    // Drain across the pointer wrap, then underflow
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
    check("unf_set", underflow, 1'b1);
    check("empty_out0", out, 4'h0);
    // Empty push+pop: push only
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'hA);
    check("pp_empty_out", out, 4'hA);
    check("pp_empty_unf", underflow, 1'b1);
    // Flush with push at count 3
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'hB);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'hC);
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'hF);
    check("flush_count", count, 3'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h3);
    check("post_flush_head", out, 4'h3);
    // Reset during a push
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h4);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h5);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'hE);
    check("rst_mid_count", count, 3'd0);
    check("rst_mid_out", out, 4'h0);
    // Random traffic exercising wrap at every fill level
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 31) == 0), 4'($urandom));
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
